decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
- Parametrised next-generation MIPS instruction-decode stage.
- Owns the IF/ID pipeline register, a parametrised register file with write-back bypass, main control decode, load-use hazard detection, and a registered ID/EX output bank with valid, stall and flush.
- Sits between fetch and execute; replaces the unregistered-output, hazard-unaware decode wrapper.

Parameters:
- DATA_W, 32: datapath and register width; legal range 16..64.
- NUM_REGS, 32: architectural register count; legal range 2..32. Register 0 reads as zero.
- BYPASS_EN, 1: 1 = same-cycle write-back to read bypass; 0 = read returns the stored value only.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_pc  in  32  PC+4 of fetched instruction
- if_instr  in  32  fetched instruction
- flush  in  1  branch taken in EX; kill younger instructions
- ex_load_in  in  1  instruction currently in EX is a load
- ex_load_rt  in  5  destination register of that load
- wb_we  in  1  write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  DATA_W  write-back data
- hazard_stall  out  1  combinational; fetch must hold PC and instruction
- ex_valid  out  1  ID/EX slot holds a real instruction
- ex_pc  out  32  registered PC+4
- ex_rs_data, ex_rt_data  out  DATA_W  registered operands
- ex_imm  out  DATA_W  registered sign-extended instr[15:0]
- ex_rs, ex_rt, ex_rd  out  5  registered instr[25:21], [20:16], [15:11]
- ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control
- ex_aluop  out  2  registered ALU op class
- ex_illegal  out  1  registered unknown-opcode flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - IF/ID valid, instruction and PC clear to 0.
  - All registers of the register file clear to 0.
  - All ex_* outputs clear to 0.
  - hazard_stall drives 0 while in reset.
- Pipeline:
  - An instruction captured into IF/ID at edge N appears on ex_* after edge N+1; latency is 2 edges from if_* to ex_*.
  - IF/ID loads if_valid/if_pc/if_instr when it is not stalled.
- Control decode on opcode instr[31:26]; signals not listed are 0:
  - 0x00: regdst, regwrite, aluop=10.
  - 0x23 lw: alusrc, memtoreg, regwrite, memread, aluop=00.
  - 0x2B sw: alusrc, memwrite, aluop=00.
  - 0x04 beq: branch, aluop=01.
  - 0x08 addi: alusrc, regwrite, aluop=00.
  - Any other opcode: all control 0 and illegal=1; ex_valid is still set.
- Uses-rt: opcodes 0x00, 0x2B and 0x04 use rt; rs is used by all opcodes.
- hazard_stall = IF/ID valid & ex_load_in & (ex_load_rt != 0) & ((ex_load_rt == rs) | (uses_rt & ex_load_rt == rt)).
- Stall:
  - IF/ID holds its contents.
  - ID/EX loads a bubble: ex_valid=0, all control and illegal 0. Data fields are don't-care; hold them.
- Flush:
  - At the next edge, IF/ID valid←0 and ex_valid←0 (bubble).
  - Flush overrides stall and if_valid.
  - hazard_stall is ignored when flush=1.
- Register file:
  - Write on rising edge when wb_we=1, wb_addr != 0 and wb_addr < NUM_REGS.
  - Reads of index 0 or index ≥ NUM_REGS return 0.
- Bypass (BYPASS_EN=1): if wb_we & wb_addr == read index & index != 0 & index < NUM_REGS, the read returns wb_data in the same cycle.
- Sign extension: ex_imm = {(DATA_W-16){instr[15]}, instr[15:0]}.
- Bubble when IF/ID is invalid: if IF/ID valid=0, ID/EX loads a bubble; register indices pass through unchanged.
- Reset mid-stall: outputs clear immediately; the first edge after rst_n rises accepts if_* normally.

Test Plan:
- Reset, then if_instr=0x8C0A0004 (lw $10,4($0)), if_pc=0x104 -> after 2 edges: ex_valid=1, memread=1, memtoreg=1, alusrc=1, regwrite=1, ex_imm=0x00000004, ex_rt=10, ex_pc=0x104.
- wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle an R-type instruction with rs=5 is decoded -> ex_rs_data=0xDEADBEEF. With BYPASS_EN=0 -> old value 0.
- ex_load_in=1, ex_load_rt=8, decoded instruction add $3,$8,$9 -> hazard_stall=1; next edge ex_valid=0 and IF/ID unchanged. With ex_load_rt=0 -> no stall.
- Stall and flush asserted together -> next edge IF/ID valid=0 and ex_valid=0; the following if_instr is accepted.
- wb write to $0 with 0x1234, then read $0 -> 0. NUM_REGS=16, read $20 -> 0.
- Opcode 0x3F -> ex_illegal=1, all control 0. addi with imm 0x8000 and DATA_W=32 -> ex_imm=0xFFFF8000.

Source files
------------

// File: rtl/decode_stage_p.sv
// MIPS instruction-decode stage: IF/ID register, bypassed register file,
// control decode, load-use hazard detection and a registered ID/EX bank.
module decode_stage_p #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_instr,
  input  logic              flush,
  input  logic              ex_load_in,
  input  logic [4:0]        ex_load_rt,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_regdst,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic [1:0]        ex_aluop,
  output logic              ex_illegal
);

  // Handshake: if_valid qualifies if_pc/if_instr. hazard_stall is the only
  // backpressure; while it is high (and flush is low) fetch must hold its
  // outputs and this stage does not consume them.

  localparam logic [5:0] NREG = 6'(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              uses_rt;
  logic              stall;
  logic              load_slot;
  logic              wb_ok;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              dec_regdst;
  logic              dec_branch;
  logic              dec_memread;
  logic              dec_memtoreg;
  logic              dec_memwrite;
  logic              dec_alusrc;
  logic              dec_regwrite;
  logic [1:0]        dec_aluop;
  logic              dec_illegal;

  assign opcode  = id_instr[31:26];
  assign rs      = id_instr[25:21];
  assign rt      = id_instr[20:16];
  assign rd      = id_instr[15:11];
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign hazard_stall = rst_n && id_valid && ex_load_in && (ex_load_rt != 5'd0) &&
                        ((ex_load_rt == rs) || (uses_rt && (ex_load_rt == rt)));

  // Flush wins: a stall against an instruction about to be killed is moot.
  assign stall     = hazard_stall && !flush;
  assign load_slot = id_valid && !stall && !flush;

  assign wb_ok = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG);

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs == 5'(i)) rs_data = regs[i];
      if (rt == 5'(i)) rt_data = regs[i];
    end
    if (BYPASS_EN != 0) begin
      if (wb_ok && (wb_addr == rs)) rs_data = wb_data;
      if (wb_ok && (wb_addr == rt)) rt_data = wb_data;
    end
  end

  always_comb begin
    dec_regdst   = 1'b0;
    dec_branch   = 1'b0;
    dec_memread  = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_aluop    = 2'b00;
    dec_illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_regdst   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b10;
      end
      OP_LW: begin
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      OP_SW: begin
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_branch   = 1'b1;
        dec_aluop    = 2'b01;
      end
      OP_ADDI: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_ok && (wb_addr == 5'(i))) regs[i] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
      id_instr <= if_instr;
    end
  end

  // Data fields follow IF/ID unless stalled; control is zeroed for bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_illegal  <= 1'b0;
    end else begin
      if (!stall) begin
        ex_pc      <= id_pc;
        ex_rs_data <= rs_data;
        ex_rt_data <= rt_data;
        ex_imm     <= {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
        ex_rs      <= rs;
        ex_rt      <= rt;
        ex_rd      <= rd;
      end
      ex_valid    <= load_slot;
      ex_regdst   <= load_slot && dec_regdst;
      ex_branch   <= load_slot && dec_branch;
      ex_memread  <= load_slot && dec_memread;
      ex_memtoreg <= load_slot && dec_memtoreg;
      ex_memwrite <= load_slot && dec_memwrite;
      ex_alusrc   <= load_slot && dec_alusrc;
      ex_regwrite <= load_slot && dec_regwrite;
      ex_aluop    <= load_slot ? dec_aluop : 2'b00;
      ex_illegal  <= load_slot && dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: a default instance and a
// BYPASS_EN=0 / NUM_REGS=16 instance driven from the same inputs.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        ex_load_in;
  logic [4:0]  ex_load_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        a_stall, a_valid, a_regdst, a_branch, a_memread, a_memtoreg;
  logic        a_memwrite, a_alusrc, a_regwrite, a_illegal;
  logic [1:0]  a_aluop;
  logic [31:0] a_pc, a_rs_data, a_rt_data, a_imm;
  logic [4:0]  a_rs, a_rt, a_rd;

  logic        b_stall, b_valid, b_regdst, b_branch, b_memread, b_memtoreg;
  logic        b_memwrite, b_alusrc, b_regwrite, b_illegal;
  logic [1:0]  b_aluop;
  logic [31:0] b_pc, b_rs_data, b_rt_data, b_imm;
  logic [4:0]  b_rs, b_rt, b_rd;

  logic [9:0]  a_ctl;
  assign a_ctl = {a_regdst, a_branch, a_memread, a_memtoreg, a_memwrite,
                  a_alusrc, a_regwrite, a_illegal, a_aluop};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .ex_load_in(ex_load_in), .ex_load_rt(ex_load_rt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(a_stall), .ex_valid(a_valid), .ex_pc(a_pc),
    .ex_rs_data(a_rs_data), .ex_rt_data(a_rt_data), .ex_imm(a_imm),
    .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd),
    .ex_regdst(a_regdst), .ex_branch(a_branch), .ex_memread(a_memread),
    .ex_memtoreg(a_memtoreg), .ex_memwrite(a_memwrite), .ex_alusrc(a_alusrc),
    .ex_regwrite(a_regwrite), .ex_aluop(a_aluop), .ex_illegal(a_illegal)
  );

  decode_stage_p #(.DATA_W(32), .NUM_REGS(16), .BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .ex_load_in(ex_load_in), .ex_load_rt(ex_load_rt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(b_stall), .ex_valid(b_valid), .ex_pc(b_pc),
    .ex_rs_data(b_rs_data), .ex_rt_data(b_rt_data), .ex_imm(b_imm),
    .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd),
    .ex_regdst(b_regdst), .ex_branch(b_branch), .ex_memread(b_memread),
    .ex_memtoreg(b_memtoreg), .ex_memwrite(b_memwrite), .ex_alusrc(b_alusrc),
    .ex_regwrite(b_regwrite), .ex_aluop(b_aluop), .ex_illegal(b_illegal)
  );

  // ctl = {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, illegal, aluop[1:0]}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  ctl;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_load_in = 1'b1; ex_load_rt = 5'd8;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    drive(1'b1, 32'h01091820, 32'h0000_0010);

    vecs[0] = '{name:"lw",   instr:32'h8C0A0004, pc:32'h104, ctl:10'b0011011000,
                imm:32'h00000004, rs:5'd0, rt:5'd10, rd:5'd0};
    vecs[1] = '{name:"add",  instr:32'h01091820, pc:32'h108, ctl:10'b1000001010,
                imm:32'h00001820, rs:5'd8, rt:5'd9,  rd:5'd3};
    vecs[2] = '{name:"sw",   instr:32'hAC45FFFC, pc:32'h10C, ctl:10'b0000110000,
                imm:32'hFFFFFFFC, rs:5'd2, rt:5'd5,  rd:5'd31};
    vecs[3] = '{name:"beq",  instr:32'h10220003, pc:32'h110, ctl:10'b0100000001,
                imm:32'h00000003, rs:5'd1, rt:5'd2,  rd:5'd0};
    vecs[4] = '{name:"addi", instr:32'h20C78000, pc:32'h114, ctl:10'b0000011000,
                imm:32'hFFFF8000, rs:5'd6, rt:5'd7,  rd:5'd16};
    vecs[5] = '{name:"ill",  instr:32'hFC221234, pc:32'h118, ctl:10'b0000000100,
                imm:32'h00001234, rs:5'd1, rt:5'd2,  rd:5'd2};

    // Reset state, with a would-be hazard presented on the inputs.
    tick();
    tick();
    check("rst_stall", 64'(a_stall), 64'd0);
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_pc",    64'(a_pc),    64'd0);
    check("rst_ctl",   64'(a_ctl),   64'd0);
    check("rst_imm",   64'(a_imm),   64'd0);
    rst_n = 1'b1; ex_load_in = 1'b0; ex_load_rt = 5'd0;
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Single instructions: 2 edges from if_* to ex_*.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check({vecs[i].name, "_valid"}, 64'(a_valid), 64'd1);
      check({vecs[i].name, "_ctl"},   64'(a_ctl),   64'(vecs[i].ctl));
      check({vecs[i].name, "_imm"},   64'(a_imm),   64'(vecs[i].imm));
      check({vecs[i].name, "_pc"},    64'(a_pc),    64'(vecs[i].pc));
      check({vecs[i].name, "_idx"},   64'({a_rs, a_rt, a_rd}),
            64'({vecs[i].rs, vecs[i].rt, vecs[i].rd}));
      check({vecs[i].name, "_data"},  64'({a_rs_data, a_rt_data}), 64'd0);
    end

    // Same-cycle write-back bypass on rs=5.
    drive(1'b1, 32'h00A00820, 32'h180);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0;
    check("byp_rs",    64'(a_rs_data), 64'hDEADBEEF);
    check("nobyp_rs",  64'(b_rs_data), 64'd0);
    drive(1'b1, 32'h00A00820, 32'h184);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("nobyp_stored", 64'(b_rs_data), 64'hDEADBEEF);

    // Writes to $0 are dropped; $20 is out of range for NUM_REGS=16.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_addr = 5'd20; wb_data = 32'h5555;
    tick();
    wb_we = 1'b0;
    drive(1'b1, 32'h00140820, 32'h1C0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("r0_read",    64'(a_rs_data), 64'd0);
    check("r20_read",   64'(a_rt_data), 64'h5555);
    check("r20_nb",     64'(b_rt_data), 64'd0);

    // Load-use hazard on add $3,$8,$9.
    drive(1'b1, 32'h01091820, 32'h200);
    tick();
    drive(1'b1, 32'h8C0A0004, 32'h204);
    ex_load_in = 1'b1; ex_load_rt = 5'd9;
    #1 check("haz_rt", 64'(a_stall), 64'd1);
    ex_load_rt = 5'd8;
    #1 check("haz_rs", 64'(a_stall), 64'd1);
    tick();
    check("haz_bubble",  64'(a_valid), 64'd0);
    check("haz_bub_ctl", 64'(a_ctl),   64'd0);
    check("haz_hold",    64'(a_stall), 64'd1);
    ex_load_in = 1'b0;
    #1 check("haz_clear", 64'(a_stall), 64'd0);
    tick();
    check("haz_rel_valid", 64'(a_valid), 64'd1);
    check("haz_rel_rd",    64'(a_rd),    64'd3);
    check("haz_rel_pc",    64'(a_pc),    64'h200);
    ex_load_in = 1'b1; ex_load_rt = 5'd0;
    #1 check("haz_rt0", 64'(a_stall), 64'd0);
    ex_load_rt = 5'd10;
    #1 check("haz_lw_no_rt", 64'(a_stall), 64'd0);
    ex_load_in = 1'b0;

    // Stall and flush together: flush wins, the next instruction is taken.
    drive(1'b1, 32'h01091820, 32'h240);
    tick();
    ex_load_in = 1'b1; ex_load_rt = 5'd8; flush = 1'b1;
    drive(1'b1, 32'h10220003, 32'h244);
    tick();
    check("fl_valid", 64'(a_valid), 64'd0);
    flush = 1'b0; ex_load_in = 1'b0;
    drive(1'b1, 32'h20C78000, 32'h250);
    #1 check("fl_nostall", 64'(a_stall), 64'd0);
    tick();
    check("fl_bubble", 64'(a_valid), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("fl_next_valid", 64'(a_valid), 64'd1);
    check("fl_next_pc",    64'(a_pc),    64'h250);
    check("fl_next_imm",   64'(a_imm),   64'hFFFF8000);

    // Asynchronous reset while stalled.
    drive(1'b1, 32'h01091820, 32'h280);
    tick();
    tick();
    ex_load_in = 1'b1; ex_load_rt = 5'd8;
    #1 check("mr_pre_stall", 64'(a_stall), 64'd1);
    check("mr_pre_valid", 64'(a_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("mr_valid", 64'(a_valid), 64'd0);
    check("mr_stall", 64'(a_stall), 64'd0);
    check("mr_pc",    64'(a_pc),    64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h20C78000, 32'h300);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("mr_first_valid", 64'(a_valid), 64'd1);
    check("mr_first_pc",    64'(a_pc),    64'h300);
    check("mr_first_rt",    64'(a_rt),    64'd7);
    ex_load_in = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
